ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter addrWidth, default 8, width of cmd_addr and haddr.
REQ-002 Parameter dataWidth, default 32, width of write/read data paths.
REQ-003 Parameter cmdDepth, default 4, command FIFO entries; power of two, at least 2.
REQ-004 hclk  input  1  sole clock; all state updates on rising edge.
REQ-005 hreset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  FIFO can accept; push occurs when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  addrWidth  target address.
REQ-010 cmd_wdata  input  dataWidth  write data; ignored for reads.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_write  output  1  completed transfer was a write.
REQ-013 rsp_rdata  output  dataWidth  read data; 0 for writes.
REQ-014 haddr  output  addrWidth  AHB address-phase address.
REQ-015 hwrite  output  1  AHB address-phase direction.
REQ-016 htrans  output  2  AHB transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are used.
REQ-017 hwdata  output  dataWidth  AHB data-phase write data.
REQ-018 hrdata  input  dataWidth  AHB read data from slave.
REQ-019 hready  input  1  slave ready; low stalls both pipeline phases.
REQ-020 busy  output  1  FIFO non-empty or data phase pending.

Function
REQ-021 cmd_ready SHALL be high exactly when the FIFO is not full, with no same-cycle pop look-ahead.
REQ-022 When the FIFO is empty, htrans, haddr and hwrite SHALL be driven to 0 (IDLE).
REQ-023 When the FIFO is non-empty, htrans, haddr and hwrite SHALL be driven combinationally from the FIFO head as NONSEQ, cmd_addr and cmd_write respectively.
REQ-024 The address phase SHALL complete at a rising edge with htrans == NONSEQ and hready high; at that edge the head is popped into the data-phase register (write flag, wdata).
REQ-025 hwdata SHALL equal the data-phase wdata while a write data phase is pending, and 0 otherwise.
REQ-026 The data phase SHALL complete at the first rising edge with hready high; read data SHALL be sampled from hrdata at that edge.
REQ-027 Address and data phases SHALL overlap, so back-to-back commands sustain one transfer per cycle while hready stays high.
REQ-028 While hready is low, haddr, hwrite, htrans and hwdata SHALL hold their values, and no pop or completion SHALL occur.
REQ-029 rsp_valid SHALL pulse in the cycle after a qualifying data-phase completion, with rsp_write and rsp_rdata registered; there is no response backpressure.
REQ-030 Latency: a read pushed at edge N with hready held high SHALL be in its address phase in cycle N+1 and its data phase in cycle N+2, with rsp_valid high in cycle N+3.
REQ-031 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers wrap modulo cmdDepth.
REQ-032 When the FIFO is full, cmd_ready SHALL be 0 and the command on cmd_* SHALL be held off without being lost.

Reset
REQ-033 While hreset is high, the FIFO SHALL be flushed, the pending data phase dropped, and no response issued for in-flight commands.
REQ-034 Reset values SHALL be: htrans=0, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0, cmd_ready=1, with pushes ignored while hreset is high.
REQ-035 The first address phase after reset deassertion SHALL occur no earlier than the cycle following the first push.

Configuration
REQ-036 Macro AHB_MASTER_WRITE_RSP_EN SHALL control write responses.
REQ-037 With AHB_MASTER_WRITE_RSP_EN defined, every completed transfer SHALL produce rsp_valid, with rsp_write=1 and rsp_rdata=0 for writes.
REQ-038 Without AHB_MASTER_WRITE_RSP_EN, only reads SHALL produce rsp_valid, and rsp_write SHALL be tied to 0.

Verification
REQ-039 Write then read: push write addr 0x10 data 0xDEADBEEF, then read 0x10, against the ahb_slave with slv_busy=0 -> rsp_valid with rsp_rdata=0xDEADBEEF three cycles after the read push.
REQ-040 Back-to-back: four writes to 0x00-0x03 pushed on consecutive cycles -> htrans NONSEQ for 4 consecutive cycles, and hwdata lags haddr by exactly one cycle.
REQ-041 Stall: slave busy held high for 3 cycles during the data phase of write 0x20/0x12345678 -> all AHB outputs stable for those 3 cycles, and mem[0x20]=0x12345678 after release.
REQ-042 Full FIFO: with hready held low, push cmdDepth commands -> cmd_ready=0 after the 4th push; release hready -> all 4 commands complete in order with none lost.
REQ-043 Reset mid-operation: assert hreset during the data phase of read 0x05 -> no rsp_valid, htrans=IDLE, busy=0, and the next command after release completes normally.
REQ-044 Macro: with and without AHB_MASTER_WRITE_RSP_EN, a single write -> rsp_valid pulses once with rsp_write=1 when defined, and no rsp_valid when undefined.

Source files
------------

// File: rtl/ahb_master.sv
// AHB-Lite master: a command FIFO feeds overlapped address/data phases, and completions come back as response pulses.
// Define AHB_MASTER_WRITE_RSP_EN to get response pulses for writes too; by default only reads respond.
module ahb_master #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32,
  parameter int cmdDepth  = 4
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic [addrWidth-1:0] haddr,
  output logic                 hwrite,
  output logic [1:0]           htrans,
  output logic [dataWidth-1:0] hwdata,
  input  logic [dataWidth-1:0] hrdata,
  input  logic                 hready,
  output logic                 busy
);

  localparam int PtrW   = (cmdDepth > 1) ? $clog2(cmdDepth) : 1;
  localparam int CountW = PtrW + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic                 fifo_write [cmdDepth];
  logic [addrWidth-1:0] fifo_addr  [cmdDepth];
  logic [dataWidth-1:0] fifo_wdata [cmdDepth];

  logic [PtrW-1:0]   wr_ptr_reg;
  logic [PtrW-1:0]   rd_ptr_reg;
  logic [CountW-1:0] count_reg;

  logic                 dp_valid_reg;
  logic                 dp_write_reg;
  logic [dataWidth-1:0] dp_wdata_reg;

  logic                 rsp_valid_reg;
  logic [dataWidth-1:0] rsp_rdata_reg;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic dp_complete;
  logic rsp_fire;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CountW'(cmdDepth));
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = !fifo_empty && hready;

  // Head entry drives the address phase directly; an empty FIFO presents IDLE with zeroed fields.
  assign htrans = fifo_empty ? HTRANS_IDLE : HTRANS_NONSEQ;
  assign haddr  = fifo_empty ? '0 : fifo_addr[rd_ptr_reg];
  assign hwrite = fifo_empty ? 1'b0 : fifo_write[rd_ptr_reg];

  assign hwdata = (dp_valid_reg && dp_write_reg) ? dp_wdata_reg : '0;
  assign busy   = !fifo_empty || dp_valid_reg;

  always_ff @(posedge hclk) begin
    if (push) begin
      fifo_write[wr_ptr_reg] <= cmd_write;
      fifo_addr[wr_ptr_reg]  <= cmd_addr;
      fifo_wdata[wr_ptr_reg] <= cmd_wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A low hready freezes both phases, so the data-phase register only advances on hready.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_wdata_reg <= '0;
    end else if (hready) begin
      dp_valid_reg <= !fifo_empty;
      dp_write_reg <= !fifo_empty && fifo_write[rd_ptr_reg];
      dp_wdata_reg <= fifo_empty ? '0 : fifo_wdata[rd_ptr_reg];
    end
  end

  assign dp_complete = dp_valid_reg && hready;

`ifdef AHB_MASTER_WRITE_RSP_EN
  logic rsp_write_reg;

  assign rsp_fire  = dp_complete;
  assign rsp_write = rsp_write_reg;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rsp_write_reg <= 1'b0;
    end else begin
      rsp_write_reg <= dp_complete && dp_write_reg;
    end
  end
`else
  assign rsp_fire  = dp_complete && !dp_write_reg;
  assign rsp_write = 1'b0;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= rsp_fire;
      rsp_rdata_reg <= (dp_complete && !dp_write_reg) ? hrdata : '0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_ahb_master.sv
// Randomized and directed bench for ahb_master with a behavioural AHB slave and an in-order scoreboard.
module tb_ahb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef AHB_MASTER_WRITE_RSP_EN
  localparam bit WRSP = 1'b1;
`else
  localparam bit WRSP = 1'b0;
`endif

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          busy;

  logic slv_busy = 1'b0;
  logic rand_stall = 1'b0;
  bit   rand_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_push_cyc = 0;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  bit [DW-1:0] model_mem [256];
  bit [DW-1:0] slv_mem [256];

  logic [1:0]    tr_htrans [4096];
  logic [AW-1:0] tr_haddr  [4096];
  logic          tr_hwrite [4096];
  logic [DW-1:0] tr_hwdata [4096];

  ahb_master #(.addrWidth(AW), .dataWidth(DW), .cmdDepth(DEPTH)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .busy(busy)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc <= cyc + 1;

  // Behavioural slave: captures the address phase, serves or stores data in the following phase.
  logic          s_dp_valid;
  logic          s_dp_write;
  logic [AW-1:0] s_dp_addr;

  assign hready = !(slv_busy || rand_stall);
  assign hrdata = (s_dp_valid && !s_dp_write) ? slv_mem[s_dp_addr] : 32'hA5A5_5A5A;

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      s_dp_valid <= 1'b0;
      s_dp_write <= 1'b0;
      s_dp_addr  <= '0;
    end else if (hready) begin
      if (s_dp_valid && s_dp_write) slv_mem[s_dp_addr] <= hwdata;
      s_dp_valid <= (htrans == 2'b10);
      s_dp_write <= hwrite;
      s_dp_addr  <= haddr;
    end
  end

  initial begin
    forever begin
      @(posedge hclk);
      #1;
      rand_stall = rand_en && ($urandom_range(0, 3) == 0);
    end
  end

  always @(negedge hclk) begin
    tr_htrans[cyc & 4095] <= htrans;
    tr_haddr[cyc & 4095]  <= haddr;
    tr_hwrite[cyc & 4095] <= hwrite;
    tr_hwdata[cyc & 4095] <= hwdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pops the oldest expectation.
  always @(negedge hclk) begin
    if (!hreset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got write=%0b rdata=%h, required no response", rsp_write, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        $display("rsp write=%0b rdata=%h (expected write=%0b rdata=%h)", rsp_write, rsp_rdata, mon_e.w, mon_e.d);
        check("rsp_write", 64'(rsp_write), 64'(mon_e.w));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.d));
      end
    end
  end

  // Issues one command; the reference model records the expected response at the handshake edge.
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge hclk);
    while (!cmd_ready && n < 500) begin
      @(negedge hclk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got cmd_ready=0 for 500 cycles, required 1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge hclk);
    if (w) begin
      model_mem[a] = d;
      if (WRSP) begin
        e.w = 1'b1;
        e.d = '0;
        exp_q.push_back(e);
      end
    end else begin
      e.w = 1'b0;
      e.d = model_mem[a];
      exp_q.push_back(e);
    end
    #1;
    cmd_valid = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge hclk);
    while ((busy || exp_q.size() != 0) && n < 1000) begin
      @(negedge hclk);
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy, exp_q.size());
    end
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p;
    int cnt;
    logic w;
    logic [AW-1:0] a;

    // Reset values, with a command offered that must be ignored.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h77;
    cmd_wdata = 32'h1111_2222;
    repeat (3) @(negedge hclk);
    check("rst_htrans", 64'(htrans), 0);
    check("rst_haddr", 64'(haddr), 0);
    check("rst_hwrite", 64'(hwrite), 0);
    check("rst_hwdata", 64'(hwdata), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_write", 64'(rsp_write), 0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_cmd_ready", 64'(cmd_ready), 1);
    @(posedge hclk);
    #1;
    cmd_valid = 1'b0;
    hreset = 1'b0;
    @(negedge hclk);
    check("post_rst_busy", 64'(busy), 0);
    check("post_rst_htrans", 64'(htrans), 0);
    @(posedge hclk);
    #1;

    // Write then read back, with read latency checks.
    push(1'b1, 8'h10, 32'hDEAD_BEEF);
    push(1'b0, 8'h10, '0);
    @(negedge hclk);
    check("rd_addr_phase_htrans", 64'(htrans), 2);
    check("rd_addr_phase_haddr", 64'(haddr), 64'h10);
    check("rd_addr_phase_hwrite", 64'(hwrite), 0);
    @(negedge hclk);
    check("rd_data_phase_hwdata", 64'(hwdata), 0);
    @(negedge hclk);
    check("rd_latency_rsp_valid", 64'(rsp_valid), 1);
    check("rd_latency_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    wait_idle();

    // Back-to-back writes: one transfer per cycle, hwdata one cycle behind haddr.
    for (int k = 0; k < 4; k++) begin
      push(1'b1, AW'(k), 32'hA000_0000 + k);
      if (k == 0) p = last_push_cyc;
    end
    repeat (3) @(negedge hclk);
    check("b2b_hwdata_before", 64'(tr_hwdata[p & 4095]), 0);
    for (int k = 0; k < 4; k++) begin
      check("b2b_htrans", 64'(tr_htrans[(p + k) & 4095]), 2);
      check("b2b_haddr", 64'(tr_haddr[(p + k) & 4095]), 64'(k));
      check("b2b_hwrite", 64'(tr_hwrite[(p + k) & 4095]), 1);
      check("b2b_hwdata", 64'(tr_hwdata[(p + k + 1) & 4095]), 64'(32'hA000_0000 + k));
    end
    check("b2b_htrans_after", 64'(tr_htrans[(p + 4) & 4095]), 0);
    wait_idle();

    // Three-cycle stall during a write data phase with a read waiting in its address phase.
    push(1'b1, 8'h20, 32'h1234_5678);
    push(1'b0, 8'h20, '0);
    p = last_push_cyc;
    slv_busy = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    slv_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_htrans", 64'(tr_htrans[(p + k) & 4095]), 2);
      check("stall_haddr", 64'(tr_haddr[(p + k) & 4095]), 64'h20);
      check("stall_hwrite", 64'(tr_hwrite[(p + k) & 4095]), 0);
      check("stall_hwdata", 64'(tr_hwdata[(p + k) & 4095]), 64'h1234_5678);
    end
    wait_idle();
    check("stall_mem", 64'(slv_mem[8'h20]), 64'h1234_5678);

    // Full FIFO with hready low; a fifth command must wait, not vanish.
    slv_busy = 1'b1;
    push(1'b1, 8'h30, 32'h1111_1111);
    push(1'b0, 8'h30, '0);
    push(1'b1, 8'h31, 32'h2222_2222);
    push(1'b0, 8'h31, '0);
    @(negedge hclk);
    check("full_cmd_ready", 64'(cmd_ready), 0);
    check("full_busy", 64'(busy), 1);
    check("full_head_haddr", 64'(haddr), 64'h30);
    fork
      push(1'b0, 8'h31, '0);
      begin
        repeat (3) @(posedge hclk);
        #1;
        slv_busy = 1'b0;
      end
    join
    wait_idle();

    // Single write: a response only when write responses are enabled.
    push(1'b1, 8'h40, 32'h4040_4040);
    cnt = 0;
    repeat (6) begin
      @(negedge hclk);
      if (rsp_valid) cnt++;
    end
    check("single_write_rsp_count", 64'(cnt), WRSP ? 1 : 0);
    wait_idle();

    // Reset during a read data phase.
    push(1'b1, 8'h05, 32'hCAFE_F00D);
    wait_idle();
    push(1'b0, 8'h05, '0);
    @(posedge hclk);
    #1;
    hreset = 1'b1;
    exp_q.delete();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h05;
    cmd_wdata = 32'hFFFF_FFFF;
    @(negedge hclk);
    check("midrst_htrans", 64'(htrans), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_rsp_valid", 64'(rsp_valid), 0);
    check("midrst_cmd_ready", 64'(cmd_ready), 1);
    check("midrst_hwdata", 64'(hwdata), 0);
    repeat (2) @(posedge hclk);
    #1;
    cmd_valid = 1'b0;
    hreset = 1'b0;
    repeat (4) begin
      @(negedge hclk);
      check("after_rst_rsp_valid", 64'(rsp_valid), 0);
      check("after_rst_busy", 64'(busy), 0);
    end
    @(posedge hclk);
    #1;
    push(1'b0, 8'h05, '0);
    wait_idle();

    // Randomized traffic with random slave wait states.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge hclk);
        #1;
      end
      w = ($urandom_range(0, 1) == 1);
      a = AW'($urandom_range(0, 15));
      push(w, a, $urandom);
    end
    rand_en = 1'b0;
    wait_idle();
    check("final_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
